sys_bus_arbiter: RTL and testbench

Shares one system-bus slave port (PS GP-master-side register bus) between NM independent system-bus requesters (e.g. housekeeping, DMA control, debug bridge).
- Each requester issues single-cycle wen/ren strobes; the arbiter buffers one request per requester, schedules them round-robin and forwards each to the slave as a single strobe.
- It returns the slave's ack, err and rdata to the owning requester.
- It sits between the requester modules and the PS-facing bus inside the top level.

---
 rtl/sys_bus_arb_pkg.sv | 23 ++
 rtl/sys_bus_rr_pick.sv | 27 ++
 rtl/sys_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_sys_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_arb_pkg.sv
// Shared types for the system-bus arbiter: FSM states, request slot layout and timeout sizing.
package sys_bus_arb_pkg;

  // Slot fields are sized for the widest supported bus; the arbiter zero-extends narrower buses.
  localparam int ARB_AW      = 32;
  localparam int ARB_DW      = 32;
  localparam int TIMEOUT_DEF = 1023;
  localparam int TMO_W       = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic              we;
  } slot_t;

endpackage

// File: rtl/sys_bus_rr_pick.sv
// Combinational round-robin picker: first pending slot at or after the pointer, as a one-hot grant.
module sys_bus_rr_pick #(
  parameter int NM = 4,
  parameter int PW = $clog2(NM)
) (
  input  logic [NM-1:0] pend,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] gnt,
  output logic          vld
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < NM; i++) begin
      idx = PW'((int'(ptr) + i) % NM);
      if (!vld && pend[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus slave between NM single-strobe requesters.
// Optional slave-wait timeout is built in when SYS_BUS_ARB_TIMEOUT_EN is defined.
module sys_bus_arbiter
  import sys_bus_arb_pkg::*;
#(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_wdata_i,
  input  logic [NM-1:0]    m_wen_i,
  input  logic [NM-1:0]    m_ren_i,
  output logic [DW-1:0]    m_rdata_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NM-1:0]    m_ovf_o,
  output logic [AW-1:0]    s_addr_o,
  output logic [DW-1:0]    s_wdata_o,
  output logic             s_wen_o,
  output logic             s_ren_o,
  input  logic [DW-1:0]    s_rdata_i,
  input  logic             s_ack_i,
  input  logic             s_err_i
);

  localparam int PW = $clog2(NM);

  arb_state_e    state, state_nxt;
  slot_t         slot_q [NM];
  logic [NM-1:0] pend, ovf, stb, done, accept, gnt_oh, pick_oh;
  logic [PW-1:0] ptr, gnt, pick_idx;
  logic          pick_vld, expired, active;
  logic          err_q, rsp_take, rsp_err;
  logic [DW-1:0] rdata_q, rsp_rdata;

  sys_bus_rr_pick #(.NM(NM), .PW(PW)) u_pick (
    .pend (pend),
    .ptr  (ptr),
    .gnt  (pick_oh),
    .vld  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NM; i++)
      if (pick_oh[i]) pick_idx = PW'(i);
  end

  always_comb begin
    gnt_oh      = '0;
    gnt_oh[gnt] = 1'b1;
  end

  // A strobe is taken when the slot is free or is being released this very cycle.
  assign stb    = m_wen_i | m_ren_i;
  assign done   = (state == RESP) ? gnt_oh : '0;
  assign accept = stb & (~pend | done);

`ifdef SYS_BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || state != WAIT) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 1'b1;
  end
  assign expired = (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    rsp_take  = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    unique case (state)
      IDLE:  if (pick_vld) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A real ack beats a simultaneous timeout expiry.
        if (s_ack_i) begin
          state_nxt = RESP;
          rsp_take  = 1'b1;
          rsp_err   = s_err_i;
          rsp_rdata = slot_q[gnt].we ? '0 : s_rdata_i;
        end else if (expired) begin
          state_nxt = RESP;
          rsp_take  = 1'b1;
          rsp_err   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      pend  <= '0;
      ovf   <= '0;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      pend  <= (pend & ~done) | accept;
      ovf   <= ovf | (stb & ~accept);
      if (state == IDLE && pick_vld) gnt <= pick_idx;
      if (state == RESP) ptr <= (gnt == PW'(NM - 1)) ? '0 : gnt + 1'b1;
    end
  end

  // Request payload and captured response carry no reset; outputs are qualified by state.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NM; k++) begin
      if (accept[k]) begin
        slot_q[k].addr  <= ARB_AW'(m_addr_i[k*AW +: AW]);
        slot_q[k].wdata <= ARB_DW'(m_wdata_i[k*DW +: DW]);
        slot_q[k].we    <= m_wen_i[k];
      end
    end
    if (rsp_take) begin
      rdata_q <= rsp_rdata;
      err_q   <= rsp_err;
    end
  end

  assign active    = rstn_i && (state != IDLE);
  assign s_addr_o  = active ? slot_q[gnt].addr[AW-1:0] : '0;
  assign s_wdata_o = active ? slot_q[gnt].wdata[DW-1:0] : '0;
  assign s_wen_o   = rstn_i && (state == ISSUE) && slot_q[gnt].we;
  assign s_ren_o   = rstn_i && (state == ISSUE) && !slot_q[gnt].we;
  assign m_ack_o   = (rstn_i && state == RESP) ? gnt_oh : '0;
  assign m_err_o   = m_ack_o & {NM{err_q}};
  assign m_rdata_o = (rstn_i && state == RESP) ? rdata_q : '0;
  assign m_ovf_o   = rstn_i ? ovf : '0;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Randomized bench for sys_bus_arbiter against a transaction-level round-robin scoreboard.
module tb_sys_bus_arbiter;

  localparam int NM  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rstn_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_wdata_i;
  logic [NM-1:0]    m_wen_i, m_ren_i;
  logic [DW-1:0]    m_rdata_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_ovf_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic             s_wen_o, s_ren_o;
  logic [DW-1:0]    s_rdata_i;
  logic             s_ack_i, s_err_i;

  sys_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .m_addr_i  (m_addr_i),
    .m_wdata_i (m_wdata_i),
    .m_wen_i   (m_wen_i),
    .m_ren_i   (m_ren_i),
    .m_rdata_o (m_rdata_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_ovf_o   (m_ovf_o),
    .s_addr_o  (s_addr_o),
    .s_wdata_o (s_wdata_o),
    .s_wen_o   (s_wen_o),
    .s_ren_o   (s_ren_o),
    .s_rdata_i (s_rdata_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0, cyc = 0;

  // Scoreboard: one buffered request per requester plus the transaction in flight.
  logic [NM-1:0] mp, mwe, movf;
  int            macc [NM];
  logic [AW-1:0] maddr [NM];
  logic [DW-1:0] mwd [NM];
  int            mptr, cur, free_at, ack_at, resp_at, ack_dly;
  logic [DW-1:0] plan_rd, resp_rd;
  logic          plan_err, resp_err;
  bit            no_ack, rd_fixed, err_all, spur, force_ack;
  int            iss_log [$];
  int            n_iss [NM];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    mp = '0; movf = '0; mwe = '0;
    mptr = 0; cur = -1; free_at = cyc; ack_at = -1; resp_at = -1;
    for (int k = 0; k < NM; k++) begin
      macc[k] = 0; n_iss[k] = 0;
    end
  endtask

  task automatic set_req(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_wen_i[k]           = w;
    m_ren_i[k]           = !w;
    m_addr_i[k*AW +: AW]  = a;
    m_wdata_i[k*DW +: DW] = d;
  endtask

  task automatic tick();
    int rk, iss, k;
    logic [NM-1:0] e_ack, e_err;
    logic [DW-1:0] e_rd;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rdata_i = '0;
    if (cur >= 0 && cyc == ack_at) begin
      s_ack_i = 1'b1; s_rdata_i = plan_rd; s_err_i = plan_err;
    end else if (force_ack || (spur && cur < 0 && $urandom_range(0, 7) == 0)) begin
      s_ack_i = 1'b1; s_rdata_i = DW'($urandom); s_err_i = 1'($urandom);
    end
    force_ack = 1'b0;
    @(negedge clk);
    rk = (cur >= 0 && cyc == resp_at) ? cur : -1;
    e_ack = '0; e_err = '0; e_rd = '0;
    if (rk >= 0) begin
      e_ack[rk] = 1'b1; e_err[rk] = resp_err; e_rd = resp_rd;
    end
    check_eq("m_ack", 64'(m_ack_o), 64'(e_ack));
    check_eq("m_err", 64'(m_err_o), 64'(e_err));
    check_eq("m_rdata", 64'(m_rdata_o), 64'(e_rd));
    check_eq("m_ovf", 64'(m_ovf_o), 64'(movf));
    iss = -1;
    if (cur < 0 && cyc >= free_at)
      for (int i = 0; i < NM; i++) begin
        k = (mptr + i) % NM;
        if (iss < 0 && mp[k] && macc[k] <= cyc - 2) iss = k;
      end
    if (iss < 0) begin
      check_eq("s_strobe_idle", 64'({s_wen_o, s_ren_o}), 64'(0));
    end else begin
      check_eq("s_wen", 64'(s_wen_o), 64'(mwe[iss]));
      check_eq("s_ren", 64'(s_ren_o), 64'(!mwe[iss]));
      check_eq("s_addr", 64'(s_addr_o), 64'(maddr[iss]));
      check_eq("s_wdata", 64'(s_wdata_o), 64'(mwd[iss]));
      cur = iss;
      iss_log.push_back(iss);
      n_iss[iss]++;
      plan_rd  = rd_fixed ? DW'(32'h100 + iss) : DW'($urandom);
      plan_err = err_all ? 1'b1 : ($urandom_range(0, 3) == 0);
      ack_at   = no_ack ? -1 : cyc + 1 + ((ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 3)));
      resp_at  = (ack_at >= 0) ? ack_at + 1 : -1;
      resp_err = plan_err;
      resp_rd  = mwe[iss] ? '0 : plan_rd;
`ifdef SYS_BUS_ARB_TIMEOUT_EN
      if (ack_at < 0 || ack_at > cyc + TMO) begin
        ack_at = -1; resp_at = cyc + TMO + 1; resp_err = 1'b1; resp_rd = '0;
      end
`endif
    end
    if (rk >= 0) mp[rk] = 1'b0;
    for (int j = 0; j < NM; j++) begin
      if (m_wen_i[j] || m_ren_i[j]) begin
        if (!mp[j]) begin
          mp[j] = 1'b1; macc[j] = cyc; mwe[j] = m_wen_i[j];
          maddr[j] = m_addr_i[j*AW +: AW]; mwd[j] = m_wdata_i[j*DW +: DW];
        end else begin
          movf[j] = 1'b1;
        end
      end
    end
    if (rk >= 0) begin
      mptr = (rk + 1) % NM; free_at = cyc + 2; cur = -1;
    end
    @(posedge clk); #1;
    cyc++;
    m_wen_i = '0; m_ren_i = '0;
  endtask

  task automatic reset_dut(input int n);
    rstn_i = 1'b0; m_wen_i = '0; m_ren_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rdata_i = '0;
    repeat (n) begin
      @(negedge clk);
      check_eq("rst_m", 64'({m_ack_o, m_err_o, m_ovf_o, s_wen_o, s_ren_o}), 64'(0));
      check_eq("rst_data", 64'({m_rdata_o, s_addr_o}), 64'(0));
      check_eq("rst_wdata", 64'(s_wdata_o), 64'(0));
      @(posedge clk); #1;
      cyc++;
    end
    rstn_i = 1'b1;
    model_clear();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    int budget = 200;
    while ((cur >= 0 || mp != '0) && budget > 0) begin
      tick();
      budget--;
    end
    check_eq("drain_busy", 64'(cur >= 0 || mp != '0), 64'(0));
  endtask

  initial begin
    rstn_i = 1'b0; m_addr_i = '0; m_wdata_i = '0; m_wen_i = '0; m_ren_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rdata_i = '0;
    no_ack = 0; rd_fixed = 0; err_all = 0; spur = 0; force_ack = 0; ack_dly = -1;
    model_clear();
    @(posedge clk); #1;
    reset_dut(2);

    // single write, slave acks in the first wait cycle
    ack_dly = 0;
    set_req(0, 1'b1, 32'h4000_0010, 32'hA5A5_A5A5);
    tick();
    drain();
    check_eq("wr_issues", 64'(n_iss[0]), 64'(1));

    // four simultaneous reads, then requester 1 alone after the pointer wraps
    reset_dut(1);
    ack_dly = -1; rd_fixed = 1; iss_log.delete();
    for (int k = 0; k < NM; k++) set_req(k, 1'b0, AW'(32'h1000 + 4 * k), '0);
    tick();
    drain();
    set_req(1, 1'b0, 32'h2000, '0);
    tick();
    drain();
    check_eq("rr_len", 64'(iss_log.size()), 64'(5));
    for (int k = 0; k < 5; k++) check_eq("rr_order", 64'(iss_log[k]), 64'((k < 4) ? k : 1));
    rd_fixed = 0;

    // repeated strobes on a pending slot
    reset_dut(1);
    set_req(2, 1'b0, 32'h3000, '0);
    tick();
    set_req(2, 1'b0, 32'h3004, '0);
    tick();
    tick();
    set_req(2, 1'b1, 32'h3008, 32'h55);
    tick();
    drain();
    run(3);
    check_eq("ovf2_sticky", 64'(m_ovf_o), 64'(4'b0100));
    check_eq("ovf2_issues", 64'(n_iss[2]), 64'(1));

    // slave error on reads
    reset_dut(1);
    err_all = 1;
    set_req(1, 1'b0, 32'h5000, '0);
    set_req(3, 1'b0, 32'h5004, '0);
    tick();
    drain();
    err_all = 0;

    // slave never answers
    reset_dut(1);
    no_ack = 1;
    set_req(3, 1'b0, 32'h6000, '0);
    tick();
    run(TMO + 20);
    no_ack = 0;

    // reset while waiting, late ack afterwards, then a normal transaction
    reset_dut(1);
    no_ack = 1;
    set_req(0, 1'b1, 32'h7000, 32'h1234);
    tick();
    run(3);
    reset_dut(1);
    force_ack = 1;
    run(4);
    no_ack = 0;
    set_req(0, 1'b0, 32'h7004, '0);
    tick();
    drain();

    // randomized traffic with spurious acks outside the wait window
    reset_dut(1);
    spur = 1;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          set_req(k, 1'($urandom), AW'($urandom), DW'($urandom));
          if ($urandom_range(0, 7) == 0) m_ren_i[k] = 1'b1;
        end
      end
      tick();
    end
    spur = 0;
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
